// File: rtl/bounded_pos_stepper_if.sv
// Request/result bus for bounded_pos_stepper: request side, result side and hit counters.
interface bounded_pos_stepper_if #(
  parameter int unsigned POS_LOG_SIZE = 10,
  parameter int unsigned SPEED_W      = 5,
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned HIT_CNT_W    = 8
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                          in_valid;
  logic                          in_ready;
  logic [CH_W-1:0]               in_ch;
  logic [POS_LOG_SIZE-1:0]       in_pos;
  logic [SPEED_W-1:0]            in_speed;
  logic                          in_dir;
  logic [POS_LOG_SIZE-1:0]       in_lo;
  logic [POS_LOG_SIZE-1:0]       in_hi;

  logic                          out_valid;
  logic                          out_ready;
  logic [CH_W-1:0]               out_ch;
  logic [POS_LOG_SIZE-1:0]       out_pos;
  logic                          out_dir;
  logic                          out_hit_lo;
  logic                          out_hit_hi;

  logic                          cnt_clr;
  logic [NUM_CH*HIT_CNT_W-1:0]   hit_cnt;

  modport master (
    output in_valid, in_ch, in_pos, in_speed, in_dir, in_lo, in_hi, out_ready, cnt_clr,
    input  in_ready, out_valid, out_ch, out_pos, out_dir, out_hit_lo, out_hit_hi, hit_cnt
  );

  modport slave (
    input  in_valid, in_ch, in_pos, in_speed, in_dir, in_lo, in_hi, out_ready, cnt_clr,
    output in_ready, out_valid, out_ch, out_pos, out_dir, out_hit_lo, out_hit_hi, hit_cnt
  );
endinterface

// File: rtl/bounded_pos_stepper.sv
// Two-stage position stepper: pos + speed, bound check, clamp (default) or reflect
// (define BOUNCE_REFLECT_EN), plus per-channel saturating hit counters.
module bounded_pos_stepper #(
  parameter int unsigned POS_LOG_SIZE = 10,
  parameter int unsigned SPEED_W      = 5,
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned HIT_CNT_W    = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  bounded_pos_stepper_if.slave  bus
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned UW   = POS_LOG_SIZE + 2;
  localparam int unsigned RW   = POS_LOG_SIZE + 3;

  logic                          s1_adv_c;
  logic                          s2_adv_c;

  logic                          s1_v;
  logic [CH_W-1:0]               s1_ch;
  logic                          s1_dir;
  logic [POS_LOG_SIZE-1:0]       s1_lo;
  logic [POS_LOG_SIZE-1:0]       s1_hi;
  logic signed [UW-1:0]          s1_unb;

  logic                          s2_v;
  logic [CH_W-1:0]               s2_ch;
  logic [POS_LOG_SIZE-1:0]       s2_pos;
  logic                          s2_dir;
  logic                          s2_hit_lo;
  logic                          s2_hit_hi;

  logic signed [UW-1:0]          unb_c;
  logic signed [UW-1:0]          lo_x_c;
  logic signed [UW-1:0]          hi_x_c;
  logic                          hit_hi_c;
  logic                          hit_lo_c;
  logic [POS_LOG_SIZE-1:0]       bound_pos_c;
  logic [POS_LOG_SIZE-1:0]       pos_c;
  logic                          dir_c;

  logic [HIT_CNT_W-1:0]          cnt_q [NUM_CH];
  logic [NUM_CH*HIT_CNT_W-1:0]   hit_cnt_c;
  logic                          xfer_hit_c;

  assign s2_adv_c     = ~s2_v | bus.out_ready;
  assign s1_adv_c     = ~s1_v | s2_adv_c;
  assign bus.in_ready = s1_adv_c;

  assign unb_c = $signed({2'b00, bus.in_pos})
               + $signed({{(UW-SPEED_W){bus.in_speed[SPEED_W-1]}}, bus.in_speed});

  // Stage 1: capture request and unbounded sum.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_v   <= 1'b0;
      s1_ch  <= '0;
      s1_dir <= 1'b0;
      s1_lo  <= '0;
      s1_hi  <= '0;
      s1_unb <= '0;
    end else if (s1_adv_c) begin
      s1_v <= bus.in_valid;
      if (bus.in_valid) begin
        s1_ch  <= bus.in_ch;
        s1_dir <= bus.in_dir;
        s1_lo  <= bus.in_lo;
        s1_hi  <= bus.in_hi;
        s1_unb <= unb_c;
      end
    end
  end

  assign lo_x_c   = $signed({2'b00, s1_lo});
  assign hi_x_c   = $signed({2'b00, s1_hi});
  assign hit_hi_c = (s1_unb > hi_x_c);
  assign hit_lo_c = ~hit_hi_c & (s1_unb < lo_x_c);

`ifdef BOUNCE_REFLECT_EN
  logic signed [RW-1:0] unb_w_c;
  logic signed [RW-1:0] lo_w_c;
  logic signed [RW-1:0] hi_w_c;
  logic signed [RW-1:0] refl_c;
  logic signed [RW-1:0] lim_lo_c;
  logic signed [RW-1:0] lim_c;

  assign unb_w_c = $signed({s1_unb[UW-1], s1_unb});
  assign lo_w_c  = $signed({3'b000, s1_lo});
  assign hi_w_c  = $signed({3'b000, s1_hi});

  // Mirror about the hit bound, then clamp; hi applied last so it wins when lo > hi.
  always_comb begin
    refl_c      = hit_hi_c ? (hi_w_c + hi_w_c - unb_w_c) : (lo_w_c + lo_w_c - unb_w_c);
    lim_lo_c    = (refl_c < lo_w_c) ? lo_w_c : refl_c;
    lim_c       = (lim_lo_c > hi_w_c) ? hi_w_c : lim_lo_c;
    bound_pos_c = lim_c[POS_LOG_SIZE-1:0];
  end
`else
  logic [RW-1:0] unused_rw_c;
  assign unused_rw_c = RW'(0);
  assign bound_pos_c = hit_hi_c ? s1_hi : s1_lo;
`endif

  always_comb begin
    pos_c = s1_unb[POS_LOG_SIZE-1:0];
    dir_c = s1_dir;
    if (hit_hi_c) begin
      pos_c = bound_pos_c;
      dir_c = 1'b0;
    end else if (hit_lo_c) begin
      pos_c = bound_pos_c;
      dir_c = 1'b1;
    end
  end

  // Stage 2: resolved result, drives the output port.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s2_v      <= 1'b0;
      s2_ch     <= '0;
      s2_pos    <= '0;
      s2_dir    <= 1'b0;
      s2_hit_lo <= 1'b0;
      s2_hit_hi <= 1'b0;
    end else if (s2_adv_c) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_ch     <= s1_ch;
        s2_pos    <= pos_c;
        s2_dir    <= dir_c;
        s2_hit_lo <= hit_lo_c;
        s2_hit_hi <= hit_hi_c;
      end
    end
  end

  assign bus.out_valid  = s2_v;
  assign bus.out_ch     = s2_ch;
  assign bus.out_pos    = s2_pos;
  assign bus.out_dir    = s2_dir;
  assign bus.out_hit_lo = s2_hit_lo;
  assign bus.out_hit_hi = s2_hit_hi;

  assign xfer_hit_c = s2_v & bus.out_ready & (s2_hit_lo | s2_hit_hi);

  // Hit counters; clear beats increment, out-of-range tags match no counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
    end else if (bus.cnt_clr) begin
      for (int unsigned k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
    end else if (xfer_hit_c) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if ((CH_W'(k) == s2_ch) && (cnt_q[k] != {HIT_CNT_W{1'b1}})) begin
          cnt_q[k] <= cnt_q[k] + HIT_CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    hit_cnt_c = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      hit_cnt_c[k*HIT_CNT_W +: HIT_CNT_W] = cnt_q[k];
    end
  end

  assign bus.hit_cnt = hit_cnt_c;
endmodule

// File: tb/tb_bounded_pos_stepper.sv
// Randomised + directed bench for bounded_pos_stepper against a behavioural queue model.
module tb_bounded_pos_stepper;
  localparam int unsigned P    = 10;
  localparam int unsigned S    = 5;
  localparam int unsigned NCH  = 3;
  localparam int unsigned HCW  = 2;
  localparam int          PMAX = (1 << P) - 1;
  localparam int          CMAX = (1 << HCW) - 1;
`ifdef BOUNCE_REFLECT_EN
  localparam int E_HI_POS = 636;
  localparam int E_LO_POS = 2;
`else
  localparam int E_HI_POS = 639;
  localparam int E_LO_POS = 0;
`endif

  typedef struct {
    int ch; int pos; int dir; int hlo; int hhi; int acc;
  } item_t;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  bounded_pos_stepper_if #(.POS_LOG_SIZE(P), .SPEED_W(S), .NUM_CH(NCH), .HIT_CNT_W(HCW)) bus ();
  bounded_pos_stepper #(.POS_LOG_SIZE(P), .SPEED_W(S), .NUM_CH(NCH), .HIT_CNT_W(HCW)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus)
  );

  int    n_chk = 0;
  int    n_err = 0;
  item_t q[$];
  int    cnt[NCH];
  int    cyc = 0;
  bit    m_acc, m_xfer;
  item_t m_it;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic fail_timeout(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: timed out (t=%0t)", nm, $time);
  endtask

  // Expected result of one step, straight from the bounding rules.
  function automatic item_t model(input int ch, pos, sp, dir, lo, hi);
    item_t r;
    int unb, rf;
    unb = pos + sp;
    r.ch = ch; r.hlo = 0; r.hhi = 0; r.dir = dir; r.acc = 0;
    r.pos = unb & PMAX;
    if (unb > hi || unb < lo) begin
      if (unb > hi) begin r.hhi = 1; r.dir = 0; end
      else begin r.hlo = 1; r.dir = 1; end
`ifdef BOUNCE_REFLECT_EN
      rf = r.hhi ? (2 * hi - unb) : (2 * lo - unb);
      if (rf < lo) rf = lo;
      if (rf > hi) rf = hi;
      r.pos = rf;
`else
      rf = 0;
      r.pos = r.hhi ? hi : lo;
`endif
    end
    return r;
  endfunction

  function automatic bit exp_in_ready();
    return (q.size() < 2) || (bus.out_ready === 1'b1);
  endfunction

  function automatic bit exp_out_valid();
    return (q.size() > 0) && (cyc - q[0].acc >= 2);
  endfunction

  // Model state: in-flight queue with accept cycle, counters.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q.delete();
      for (int k = 0; k < NCH; k++) cnt[k] = 0;
    end else begin
      m_acc  = (bus.in_valid === 1'b1) && exp_in_ready();
      m_xfer = exp_out_valid() && (bus.out_ready === 1'b1);
      if (bus.cnt_clr === 1'b1) begin
        for (int k = 0; k < NCH; k++) cnt[k] = 0;
      end else if (m_xfer && (q[0].hlo || q[0].hhi) && q[0].ch < NCH) begin
        if (cnt[q[0].ch] < CMAX) cnt[q[0].ch]++;
      end
      if (m_xfer) void'(q.pop_front());
      if (m_acc) begin
        m_it = model(int'(bus.in_ch), int'(bus.in_pos), int'($signed(bus.in_speed)),
                     int'(bus.in_dir), int'(bus.in_lo), int'(bus.in_hi));
        m_it.acc = cyc;
        q.push_back(m_it);
      end
      cyc++;
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge CLK) begin
    chk("in_ready", int'(bus.in_ready), int'(exp_in_ready()));
    chk("out_valid", int'(bus.out_valid), int'(exp_out_valid()));
    if (exp_out_valid() && bus.out_valid === 1'b1) begin
      chk("out_ch", int'(bus.out_ch), q[0].ch);
      chk("out_pos", int'(bus.out_pos), q[0].pos);
      chk("out_dir", int'(bus.out_dir), q[0].dir);
      chk("out_hit_lo", int'(bus.out_hit_lo), q[0].hlo);
      chk("out_hit_hi", int'(bus.out_hit_hi), q[0].hhi);
    end
    for (int k = 0; k < NCH; k++) chk("hit_cnt", int'(bus.hit_cnt[k*HCW +: HCW]), cnt[k]);
  end

  task automatic set_req(input int ch, pos, sp, dir, lo, hi);
    bus.in_ch    = 2'(ch);
    bus.in_pos   = P'(pos);
    bus.in_speed = S'(sp);
    bus.in_dir   = 1'(dir);
    bus.in_lo    = P'(lo);
    bus.in_hi    = P'(hi);
  endtask

  // Offer a request until accepted; starts and ends 1 time unit after a rising edge.
  task automatic send(input int ch, pos, sp, dir, lo, hi);
    bit rdy, done;
    set_req(ch, pos, sp, dir, lo, hi);
    bus.in_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge CLK); rdy = bus.in_ready;
      @(posedge CLK); #1; done = rdy;
    end
    if (!done) fail_timeout("send");
  endtask

  task automatic one_shot(input string nm, input int ch, pos, sp, dir, lo, hi,
                          input int epos, edir, elo, ehi, input bit clr);
    bit seen;
    bus.out_ready = 1'b1;
    send(ch, pos, sp, dir, lo, hi);
    bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge CLK); seen = bus.out_valid;
    end
    if (!seen) fail_timeout(nm);
    else begin
      chk({nm, "_pos"}, int'(bus.out_pos), epos);
      chk({nm, "_dir"}, int'(bus.out_dir), edir);
      chk({nm, "_hit_lo"}, int'(bus.out_hit_lo), elo);
      chk({nm, "_hit_hi"}, int'(bus.out_hit_hi), ehi);
    end
    bus.cnt_clr = clr;
    @(posedge CLK); #1;
    bus.cnt_clr = 1'b0;
  endtask

  task automatic chk_cnt(input string nm, input int k, input int exp_v);
    chk(nm, int'(bus.hit_cnt[k*HCW +: HCW]), exp_v);
  endtask

  initial begin
    int acc_n, tag, lo, hi, pos, sp;
    RST_N = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.cnt_clr = 1'b0;
    set_req(0, 0, 0, 0, 0, 0);
    @(posedge CLK); #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_pos", int'(bus.out_pos), 0);
    chk("rst_out_ch", int'(bus.out_ch), 0);
    chk("rst_hit_cnt", int'(bus.hit_cnt), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    @(posedge CLK); #2;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("post_rst_in_ready", int'(bus.in_ready), 1);

    // Hand-computed pins of the bounding rules.
    one_shot("hi_hit", 0, 635, 7, 1, 0, 639, E_HI_POS, 0, 0, 1, 1'b0);
    one_shot("lo_hit", 0, 3, -5, 0, 0, 639, E_LO_POS, 1, 1, 0, 1'b0);
    one_shot("lo_equal", 0, 5, -5, 0, 0, 639, 0, 0, 0, 0, 1'b0);
    one_shot("lo_gt_hi", 0, 60, 1, 0, 100, 50, 50, 0, 0, 1, 1'b0);

    // Backpressure: output stalled, only two requests fit.
    bus.out_ready = 1'b0;
    tag = 0; acc_n = 0;
    set_req(0, 20, 1, 1, 0, 1023);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bit rdy;
      @(negedge CLK); rdy = bus.in_ready;
      @(posedge CLK); #1;
      if (rdy) begin acc_n++; tag++; set_req(tag % 4, 20 + tag * 10, 1, 1, 0, 1023); end
    end
    chk("bp_accepts", acc_n, 2);
    bus.out_ready = 1'b1;
    while (tag < 8) begin
      send(tag % 4, 20 + tag * 10, 1, 1, 0, 1023);
      tag++;
    end
    bus.in_valid = 1'b0;
    repeat (4) @(posedge CLK); #1;

    // Counters: saturation, clear-beats-increment, out-of-range tag.
    bus.cnt_clr = 1'b1; @(posedge CLK); #1; bus.cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) one_shot("sat_hit", 1, 635, 7, 1, 0, 639, E_HI_POS, 0, 0, 1, 1'b0);
    chk_cnt("sat_cnt1", 1, 3);
    chk_cnt("sat_cnt0", 0, 0);
    one_shot("clr_hit", 1, 635, 7, 1, 0, 639, E_HI_POS, 0, 0, 1, 1'b1);
    chk_cnt("clr_wins", 1, 0);
    one_shot("oor_hit", 3, 3, -5, 0, 0, 639, E_LO_POS, 1, 1, 0, 1'b0);
    chk("oor_no_cnt", int'(bus.hit_cnt), 0);
    one_shot("after_hit", 1, 3, -5, 0, 0, 639, E_LO_POS, 1, 1, 0, 1'b0);
    chk_cnt("after_cnt1", 1, 1);

    // Reset with both stages full.
    bus.out_ready = 1'b0;
    send(0, 100, 1, 1, 0, 1023);
    send(1, 200, 1, 1, 0, 1023);
    bus.in_valid = 1'b0;
    chk("full_in_ready", int'(bus.in_ready), 0);
    #2; RST_N = 1'b0; #1;
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_hit_cnt", int'(bus.hit_cnt), 0);
    @(posedge CLK); #2; RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("mid_rst_in_ready", int'(bus.in_ready), 1);
    chk("mid_rst_no_out", int'(bus.out_valid), 0);

    // Random traffic with random backpressure and occasional clears.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        lo = int'($urandom_range(0, 1023)); hi = int'($urandom_range(0, 1023));
      end else begin
        lo = int'($urandom_range(0, 600)); hi = lo + int'($urandom_range(0, 423));
      end
      case ($urandom_range(0, 2))
        0:       pos = hi - int'($urandom_range(0, 12));
        1:       pos = lo + int'($urandom_range(0, 12));
        default: pos = int'($urandom_range(0, 1023));
      endcase
      if (pos < 0) pos = 0;
      if (pos > PMAX) pos = PMAX;
      sp = int'($urandom_range(0, 31)) - 16;
      set_req(int'($urandom_range(0, 3)), pos, sp, int'($urandom_range(0, 1)), lo, hi);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.cnt_clr   = ($urandom_range(0, 60) == 0);
      @(posedge CLK); #1;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.cnt_clr = 1'b0;
    repeat (6) @(posedge CLK); #1;
    chk("drained_out_valid", int'(bus.out_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
